// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with start/busy/done handshake, iterative MUL and DIVU
//
// Purpose:
//   Executes one operation per start request. Single-cycle ops (add, sub,
//   logic, shifts, compare, branches, nop) register their result on the edge
//   that samples start. Unsigned MUL (shift-add) and DIVU (restoring divide)
//   run one step per clock and finish WIDTH edges after the start edge.
//   Flags are registered and change only on the edge that completes an op.
//
// Parameters:
//   WIDTH       operand width in bits (>= 4)
//   SIGNED_CMP  1: CMP/BLT/BGE order operands as two's complement; 0: unsigned
//
// Ports:
//   Clk     in   clock
//   reset   in   asynchronous active-high reset
//   start   in   op request, sampled only while busy=0
//   Alu_op  in   4-bit opcode, sampled with start
//   DatA    in   operand A, sampled with start
//   DatB    in   operand B / shift amount, sampled with start
//   busy    out  iterative op in progress
//   done    out  one-cycle pulse; Rslt/branch/flags valid from this cycle
//   Rslt    out  2*WIDTH registered result, held until the next done
//   branch  out  registered branch decision, high only with done
//   flags   out  {V,C,GT,LT,Z}, registered

module alu_mc #(
  parameter int WIDTH      = 8,
  parameter bit SIGNED_CMP = 1'b1
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         Alu_op,
  input  logic [WIDTH-1:0]   DatA,
  input  logic [WIDTH-1:0]   DatB,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] Rslt,
  output logic               branch,
  output logic [4:0]         flags
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;

  // Shift amounts at or beyond the 2*WIDTH result width flush to zero.
  localparam logic [WIDTH-1:0] SH_LIMIT  = WIDTH'(W2);
  localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);

  // Bit positions inside flags = {V,C,GT,LT,Z}
  localparam int FV  = 4;
  localparam int FC  = 3;
  localparam int FGT = 2;
  localparam int FLT = 1;
  localparam int FZ  = 0;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_SHL  = 4'd4;
  localparam logic [3:0] OP_SHR  = 4'd5;
  localparam logic [3:0] OP_CMP  = 4'd6;
  localparam logic [3:0] OP_MUL  = 4'd7;
  localparam logic [3:0] OP_DIVU = 4'd8;
  localparam logic [3:0] OP_BEQ  = 4'd9;
  localparam logic [3:0] OP_BNE  = 4'd10;
  localparam logic [3:0] OP_BLT  = 4'd11;
  localparam logic [3:0] OP_BGE  = 4'd12;
  localparam logic [3:0] OP_BOF  = 4'd13;
  localparam logic [3:0] OP_B    = 4'd14;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t            state;
  logic [W2-1:0]     acc;     // MUL: {partial hi, multiplier lo}; DIVU: {remainder, quotient}
  logic [WIDTH-1:0]  opnd;    // MUL: multiplicand; DIVU: divisor
  logic              is_div;
  logic [CW-1:0]     cnt;

  // ------------------------------------------------------------------
  // Single-cycle datapath
  // ------------------------------------------------------------------
  logic [WIDTH:0]    add_sum;
  logic [WIDTH-1:0]  sub_diff;
  logic [W2-1:0]     a_ext;
  logic              cmp_lt;
  logic              cmp_gt;

  always_comb begin
    add_sum  = {1'b0, DatA} + {1'b0, DatB};
    sub_diff = DatA - DatB;
    a_ext    = {{WIDTH{1'b0}}, DatA};
    if (SIGNED_CMP) begin
      cmp_lt = $signed(DatA) < $signed(DatB);
      cmp_gt = $signed(DatA) > $signed(DatB);
    end else begin
      cmp_lt = DatA < DatB;
      cmp_gt = DatA > DatB;
    end
  end

  logic [W2-1:0] sc_rslt;
  logic [4:0]    sc_flags;
  logic          sc_branch;
  logic          start_iter;

  // Ops only touch the flag fields they define; every other field keeps
  // its previous value. Branches read the flags held before the op.
  always_comb begin
    sc_rslt    = '0;
    sc_flags   = flags;
    sc_branch  = 1'b0;
    start_iter = 1'b0;
    case (Alu_op)
      OP_ADD: begin
        sc_rslt      = {{(WIDTH-1){1'b0}}, add_sum};
        sc_flags[FC] = add_sum[WIDTH];
        sc_flags[FV] = (DatA[WIDTH-1] == DatB[WIDTH-1]) &&
                       (add_sum[WIDTH-1] != DatA[WIDTH-1]);
        sc_flags[FZ] = (add_sum[WIDTH-1:0] == '0);
      end
      OP_SUB: begin
        sc_rslt      = {{WIDTH{1'b0}}, sub_diff};
        sc_flags[FC] = (DatA < DatB);
        sc_flags[FV] = (DatA[WIDTH-1] != DatB[WIDTH-1]) &&
                       (sub_diff[WIDTH-1] != DatA[WIDTH-1]);
        sc_flags[FZ] = (sub_diff == '0);
      end
      OP_AND: sc_rslt = {{WIDTH{1'b0}}, DatA & DatB};
      OP_XOR: sc_rslt = {{WIDTH{1'b0}}, DatA ^ DatB};
      OP_SHL: sc_rslt = (DatB >= SH_LIMIT) ? '0 : (a_ext << DatB);
      OP_SHR: sc_rslt = (DatB >= SH_LIMIT) ? '0 : (a_ext >> DatB);
      OP_CMP: begin
        sc_flags[FZ]  = (DatA == DatB);
        sc_flags[FLT] = cmp_lt;
        sc_flags[FGT] = cmp_gt;
      end
      OP_MUL: start_iter = 1'b1;
      OP_DIVU: begin
        if (DatB == '0) begin
          // Divide by zero resolves immediately: quotient all ones, remainder A.
          sc_rslt      = {DatA, {WIDTH{1'b1}}};
          sc_flags[FV] = 1'b1;
          sc_flags[FZ] = 1'b0;
        end else begin
          start_iter = 1'b1;
        end
      end
      OP_BEQ: sc_branch = flags[FZ];
      OP_BNE: sc_branch = ~flags[FZ];
      OP_BLT: sc_branch = flags[FLT];
      OP_BGE: sc_branch = flags[FGT] | flags[FZ];
      OP_BOF: sc_branch = flags[FV];
      OP_B:   sc_branch = 1'b1;
      default: ;  // NOP: zero result, flags untouched
    endcase
  end

  // ------------------------------------------------------------------
  // Iterative datapath: one MUL or DIVU step per BUSY edge
  // ------------------------------------------------------------------
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_next;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_trial;
  logic             div_ok;
  logic [WIDTH-1:0] div_rem;
  logic [W2-1:0]    div_next;
  logic [W2-1:0]    step_next;

  always_comb begin
    // Shift-add: conditionally add multiplicand to the high half, then shift
    // the whole accumulator right so the next multiplier bit lands in bit 0.
    mul_sum  = {1'b0, acc[W2-1:WIDTH]} +
               (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Restoring divide: shift the next dividend bit into the remainder and
    // keep the subtraction only if it did not go negative.
    div_sh    = {acc[W2-1:WIDTH], acc[WIDTH-1]};
    div_trial = div_sh - {1'b0, opnd};
    div_ok    = ~div_trial[WIDTH];
    div_rem   = div_ok ? div_trial[WIDTH-1:0] : div_sh[WIDTH-1:0];
    div_next  = {div_rem, acc[WIDTH-2:0], div_ok};

    step_next = is_div ? div_next : mul_next;
  end

  // ------------------------------------------------------------------
  // Control FSM with registered outputs
  // ------------------------------------------------------------------
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      branch <= 1'b0;
      Rslt   <= '0;
      flags  <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      cnt    <= '0;
    end else begin
      done   <= 1'b0;
      branch <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (start_iter) begin
              if (Alu_op == OP_MUL) begin
                acc  <= {{WIDTH{1'b0}}, DatB};
                opnd <= DatA;
              end else begin
                acc  <= {{WIDTH{1'b0}}, DatA};
                opnd <= DatB;
              end
              is_div <= (Alu_op == OP_DIVU);
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= S_BUSY;
            end else begin
              Rslt   <= sc_rslt;
              flags  <= sc_flags;
              branch <= sc_branch;
              done   <= 1'b1;
            end
          end
        end
        S_BUSY: begin
          // start is not looked at here: requests while busy are dropped.
          acc <= step_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_STEP) begin
            Rslt <= step_next;
            if (is_div) begin
              flags[FZ] <= (step_next[WIDTH-1:0] == '0);
              flags[FV] <= 1'b0;
            end else begin
              flags[FZ] <= (step_next == '0);
            end
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
